my_rr_mux: RTL and testbench
============================

# my_rr_mux

Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshakes on every input and on the output. It is the successor to the 2:1 combinational `my_mux`. Channel choice is either fixed by an external select or made by a built-in round-robin arbiter. Typical use: funnelling several producer streams into one consumer stage behind a single pipeline register.

## Interface
Parameters:
- `WIDTH`, 8: data width per channel, ≥1.
- `N`, 4: channel count, ≥2.
- `SELW`, `$clog2(N)`: select/channel-index width (derived; not overridden).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `mode`  in  1  0 = fixed select, 1 = round-robin.
- `sel`  in  SELW  channel index used when `mode`=0.
- `in_data`  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid`  in  N  per-channel valid.
- `in_ready`  out  N  per-channel ready; combinational.
- `out_data`  out  WIDTH  registered data.
- `out_chan`  out  SELW  registered index of the channel that supplied `out_data`.
- `out_valid`  out  1  registered valid.
- `out_ready`  in  1  consumer ready.

## Operation
- One output register holds `out_data`, `out_chan` and `out_valid`.
- `load = !out_valid || out_ready`. The register may accept a word this cycle.
- Grant (combinational, at most one channel):
  - `mode`=0: grant `sel` iff `sel < N` and `in_valid[sel]`. `sel ≥ N` grants nothing and drives all `in_ready` low.
  - `mode`=1: grant the first i with `in_valid[i]`, searching from `ptr+1` upward and wrapping N-1→0, ending at `ptr`. With no valid input there is no grant.
- `in_ready[i] = load && grant valid && grant == i`. All other `in_ready` bits are 0. `in_ready` never depends on `in_valid` of a non-granted channel.
- Input transfer on channel i: `in_valid[i] && in_ready[i]`. On the edge, `out_data` ← channel i data, `out_chan` ← i, `out_valid` ← 1.
- Output transfer: `out_valid && out_ready`. If no input transfer happens in the same cycle, `out_valid` ← 0. `out_data` and `out_chan` hold their values.
- Simultaneous output and input transfer: the register is overwritten with the new word and `out_valid` stays 1. This gives full throughput, one word per cycle.
- Round-robin pointer `ptr` (SELW bits):
  - ← granted index on every input transfer, in either mode.
  - Otherwise holds, including across `mode` changes.
- `out_valid`=1 with `out_ready`=0: `out_data` and `out_chan` are stable, and all `in_ready` bits are 0.
- `mode` or `sel` changing while the output is stalled has no effect on the held word.

## Timing
- Reset values (asynchronous assert; release is synchronous to `clk`):
  - `out_valid`=0, `out_data`=0, `out_chan`=0.
  - `ptr`=N-1, so channel 0 has first priority after reset.
- `in_ready` settles combinationally from `mode`, `sel`, `in_valid`, `ptr`, `out_valid` and `out_ready` in the same cycle.
- Latency is 1 cycle: an input transfer at edge k makes `out_valid`=1 and `out_data` visible after edge k.
- Throughput: 1 word/cycle while `out_ready`=1.
- Reset asserted mid-transfer: the word in the register is discarded, outputs immediately go to reset values, and no input transfer is counted.
- No combinational path from `in_data` to `out_data`.

## Test plan
- Reset, then fixed mode (N=4, WIDTH=8): `mode`=0, `sel`=2, `in_valid`=4'b1111, channel data 0x10/0x11/0x12/0x13, `out_ready`=1 → only `in_ready[2]`=1; the next cycle shows `out_data`=0x12, `out_chan`=2, `out_valid`=1.
- Round-robin fairness: `mode`=1, all four channels valid continuously, `out_ready`=1 → `out_chan` sequence 0,1,2,3,0,1 on consecutive cycles with no bubbles.
- Round-robin skip and wrap: `in_valid`=4'b1010 after `ptr`=3 → grants 1, 3, 1, 3. With a single valid channel 2 → it is granted every cycle.
- Backpressure: `out_ready`=0 for 3 cycles with word 0x11 held → `out_data`=0x11 stable, all `in_ready`=0. Raising `out_ready` → the next word loads in the same cycle the held word is consumed.
- Out-of-range select: N=3 build with `sel`=3, `mode`=0 → all `in_ready`=0, and `out_valid` falls to 0 after draining.
- Asynchronous reset mid-stream: assert `rst` between edges while `out_valid`=1 → `out_valid`=0 and `out_data`=0 immediately. After release, round-robin restarts at channel 0.

Source files
------------

// File: rtl/my_rr_mux.sv
// N-channel registered mux with valid/ready on every port.
// Channel is picked by a fixed select or by a round-robin arbiter.
module my_rr_mux #(
    parameter  int WIDTH = 8,
    parameter  int N     = 4,
    localparam int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_chan,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [WIDTH-1:0] r_out_data;
    logic [SELW-1:0]  r_out_chan;
    logic             r_out_valid;
    logic [SELW-1:0]  r_ptr;

    logic             w_load;
    logic             w_gnt_vld;
    logic [SELW-1:0]  w_gnt_idx;
    logic             w_xfer;
    logic [WIDTH-1:0] w_gnt_data;

    assign w_load = !r_out_valid || out_ready;

    // Round-robin searches ptr+1 .. ptr, wrapping; fixed mode ignores sel >= N.
    always_comb begin
        int cand;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        cand      = 0;
        if (mode) begin
            for (int k = 1; k <= N; k++) begin
                cand = (int'(r_ptr) + k) % N;
                if (!w_gnt_vld && in_valid[cand]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_idx = SELW'(cand);
                end
            end
        end else if (int'(sel) < N) begin
            w_gnt_vld = in_valid[sel];
            w_gnt_idx = sel;
        end
    end

    always_comb begin
        in_ready = '0;
        if (w_load && w_gnt_vld) begin
            in_ready[w_gnt_idx] = 1'b1;
        end
    end

    assign w_xfer     = w_load && w_gnt_vld;
    assign w_gnt_data = in_data[int'(w_gnt_idx)*WIDTH +: WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= SELW'(N - 1);
        end else if (w_xfer) begin
            r_out_data  <= w_gnt_data;
            r_out_chan  <= w_gnt_idx;
            r_out_valid <= 1'b1;
            r_ptr       <= w_gnt_idx;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_my_rr_mux.sv
// Randomized and directed checks of my_rr_mux against a behavioural model.
module tb_my_rr_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic        mode4;
    logic [1:0]  sel4;
    logic [31:0] data4;
    logic [3:0]  v4;
    logic [3:0]  rdy4;
    logic [7:0]  od4;
    logic [1:0]  oc4;
    logic        ov4;
    logic        or4;

    logic        mode3;
    logic [1:0]  sel3;
    logic [23:0] data3;
    logic [2:0]  v3;
    logic [2:0]  rdy3;
    logic [7:0]  od3;
    logic [1:0]  oc3;
    logic        ov3;
    logic        or3;

    my_rr_mux #(.WIDTH(8), .N(4)) u_dut4 (
        .clk(clk), .rst(rst), .mode(mode4), .sel(sel4),
        .in_data(data4), .in_valid(v4), .in_ready(rdy4),
        .out_data(od4), .out_chan(oc4), .out_valid(ov4), .out_ready(or4)
    );

    my_rr_mux #(.WIDTH(8), .N(3)) u_dut3 (
        .clk(clk), .rst(rst), .mode(mode3), .sel(sel3),
        .in_data(data3), .in_valid(v3), .in_ready(rdy3),
        .out_data(od3), .out_chan(oc3), .out_valid(ov3), .out_ready(or3)
    );

    int n_cmp = 0;
    int n_err = 0;

    // reference state for the N=4 instance
    bit         m_v;
    logic [7:0] m_d;
    int         m_c;
    int         m_p;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Channel the rules pick, or -1 for no grant.
    function automatic int ref_pick(input bit md, input int s, input logic [3:0] v,
                                    input int p, input int n);
        if (!md) return (s < n && v[s]) ? s : -1;
        for (int k = 1; k <= n; k++) begin
            if (v[(p + k) % n]) return (p + k) % n;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_v = 1'b0;
        m_d = 8'h00;
        m_c = 0;
        m_p = 3;
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic step4(input bit md, input logic [1:0] s, input logic [3:0] v,
                         input logic [31:0] d, input bit r);
        int         g;
        bit         ld;
        logic [3:0] exp_rdy;
        mode4 = md; sel4 = s; v4 = v; data4 = d; or4 = r;
        #2;
        ld = !m_v || r;
        g  = ref_pick(md, int'(s), v, m_p, 4);
        exp_rdy = (ld && g >= 0) ? 4'(1 << g) : 4'b0000;
        chk("in_ready", 32'(rdy4), 32'(exp_rdy));
        @(posedge clk);
        if (ld && g >= 0) begin
            m_v = 1'b1;
            m_d = d[g*8 +: 8];
            m_c = g;
            m_p = g;
        end else if (r) begin
            m_v = 1'b0;
        end
        #1;
        chk("out_valid", 32'(ov4), 32'(m_v));
        chk("out_data",  32'(od4), 32'(m_d));
        chk("out_chan",  32'(oc4), 32'(m_c));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_valid", 32'(ov4), 32'd0);
        chk("rst_data",  32'(od4), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    localparam logic [31:0] D4 = 32'h13121110;

    initial begin
        rst = 1'b1;
        mode4 = 1'b0; sel4 = 2'd0; data4 = '0; v4 = '0; or4 = 1'b1;
        mode3 = 1'b0; sel3 = 2'd0; data3 = '0; v3 = '0; or3 = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_chan", 32'(oc4), 32'd0);
        rst = 1'b0;

        // fixed select picks channel 2 only
        step4(1'b0, 2'd2, 4'hF, D4, 1'b1);
        chk("fixed_data", 32'(od4), 32'h12);
        chk("fixed_chan", 32'(oc4), 32'd2);

        // fairness from reset: 0,1,2,3,0,1 without bubbles
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step4(1'b1, 2'd0, 4'hF, D4, 1'b1);
            chk("rr_seq", 32'(oc4), 32'(i % 4));
            chk("rr_nobubble", 32'(ov4), 32'd1);
        end

        // skip and wrap with ptr parked at 3
        do_reset();
        step4(1'b1, 2'd0, 4'b1000, D4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step4(1'b1, 2'd0, 4'b1010, D4, 1'b1);
            chk("rr_skip", 32'(oc4), (i % 2 == 0) ? 32'd1 : 32'd3);
        end
        for (int i = 0; i < 3; i++) begin
            step4(1'b1, 2'd0, 4'b0100, D4, 1'b1);
            chk("rr_single", 32'(oc4), 32'd2);
        end

        // backpressure: hold 0x11 while mode/sel wander, then refill on release
        step4(1'b0, 2'd1, 4'hF, D4, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step4(1'(i % 2), 2'(i + 2), 4'hF, D4, 1'b0);
            chk("bp_hold", 32'(od4), 32'h11);
            chk("bp_ready", 32'(rdy4), 32'd0);
        end
        step4(1'b0, 2'd2, 4'hF, D4, 1'b1);
        chk("bp_refill", 32'(od4), 32'h12);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step4(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)), $urandom,
                  ($urandom_range(0, 3) != 0));
        end

        // async reset while a word is held
        step4(1'b1, 2'd0, 4'hF, D4, 1'b1);
        step4(1'b1, 2'd0, 4'hF, D4, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(ov4), 32'd0);
        chk("arst_data",  32'(od4), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step4(1'b1, 2'd0, 4'hF, D4, 1'b1);
        chk("arst_restart", 32'(oc4), 32'd0);

        // N=3 build: sel=3 is out of range
        mode3 = 1'b0; sel3 = 2'd1; v3 = 3'b111; data3 = 24'h222120; or3 = 1'b1;
        #2;
        chk("n3_ready", 32'(rdy3), 32'b010);
        @(posedge clk);
        #1;
        chk("n3_valid", 32'(ov3), 32'd1);
        chk("n3_data",  32'(od3), 32'h21);
        sel3 = 2'd3;
        #2;
        chk("n3_oor_ready", 32'(rdy3), 32'd0);
        @(posedge clk);
        #1;
        chk("n3_drain", 32'(ov3), 32'd0);
        chk("n3_hold",  32'(od3), 32'h21);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
